// File: rtl/pong_pkg.sv
// Shared pong constants: screen bounds, paddle geometry, keycodes and paddle FSM states.
// Used by the paddle controller, the ball and the colour mapper.
package pong_pkg;

  localparam logic [9:0] X_POS    = 10'd40;
  localparam logic [9:0] Y_CENTER = 10'd240;
  localparam logic [9:0] Y_MIN    = 10'd0;
  localparam logic [9:0] Y_MAX    = 10'd479;
  localparam logic [9:0] PADDLE_S = 10'd24;
  localparam logic [9:0] Y_TOP    = Y_MIN + PADDLE_S;
  localparam logic [9:0] Y_BOT    = Y_MAX - PADDLE_S;

  localparam logic [3:0] MIN_SPEED   = 4'd2;
  localparam logic [3:0] MAX_SPEED   = 4'd6;
  localparam logic [3:0] SCORE_LIMIT = 4'd9;

  localparam logic [7:0] KEY_UP   = 8'h1A;
  localparam logic [7:0] KEY_DOWN = 8'h16;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, FROZEN} paddle_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} key_dir_t;

  function automatic key_dir_t decode_key(input logic [7:0] key);
    if (key == KEY_UP)   return DIR_UP;
    if (key == KEY_DOWN) return DIR_DOWN;
    return DIR_NONE;
  endfunction

  // Pins a signed candidate row so the whole paddle stays on screen.
  function automatic logic [9:0] clamp_y(input logic signed [10:0] y);
    logic signed [10:0] lo;
    logic signed [10:0] hi;
    lo = signed'({1'b0, Y_TOP});
    hi = signed'({1'b0, Y_BOT});
    if (y < lo) return Y_TOP;
    if (y > hi) return Y_BOT;
    return y[9:0];
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: keycode and scores in, paddle geometry out.
interface paddle_ctrl_if;
  logic [7:0] keycode;
  logic [3:0] Score1;
  logic [3:0] Score2;
  logic [9:0] PaddleX;
  logic [9:0] PaddleY;
  logic [9:0] PaddleS;

  modport master (output keycode, Score1, Score2, input PaddleX, PaddleY, PaddleS);
  modport slave  (input keycode, Score1, Score2, output PaddleX, PaddleY, PaddleS);
endinterface

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-cycle tick on each synchronised rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);
  logic s1, s2, s3;

  // NOTE: non-blocking assignments make s1->s2->s3 a real shift chain; blocking
  // would collapse the three flops into one in simulation.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= frame_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;
endmodule

// File: rtl/paddle_ctrl.sv
// Keyboard-driven paddle: accelerating per-frame motion, screen clamping,
// and a freeze at game over that only reset clears.
module paddle_ctrl
  import pong_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_clk,
  paddle_ctrl_if.slave  pif
);
  logic          tick;
  paddle_state_t state, state_nxt;
  logic [3:0]    speed, speed_nxt;
  logic [9:0]    y_q, y_nxt;
  key_dir_t      dir;
  logic          game_over;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign dir       = decode_key(pif.keycode);
  assign game_over = (pif.Score1 > SCORE_LIMIT) || (pif.Score2 > SCORE_LIMIT);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    y_nxt     = y_q;
    if (game_over) begin
      state_nxt = FROZEN;
      speed_nxt = 4'd0;
      y_nxt     = Y_CENTER;
    end else if (state != FROZEN) begin
      case (dir)
        DIR_UP: begin
          state_nxt = MOVE_UP;
          speed_nxt = (state != MOVE_UP) ? MIN_SPEED :
                      (speed >= MAX_SPEED) ? MAX_SPEED : speed + 4'd1;
          y_nxt     = clamp_y(signed'({1'b0, y_q}) - signed'({7'd0, speed_nxt}));
        end
        DIR_DOWN: begin
          state_nxt = MOVE_DOWN;
          speed_nxt = (state != MOVE_DOWN) ? MIN_SPEED :
                      (speed >= MAX_SPEED) ? MAX_SPEED : speed + 4'd1;
          y_nxt     = clamp_y(signed'({1'b0, y_q}) + signed'({7'd0, speed_nxt}));
        end
        default: begin
          state_nxt = IDLE;
          speed_nxt = 4'd0;
        end
      endcase
    end
  end

  // Everything advances on the frame tick only; other cycles hold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      speed <= 4'd0;
      y_q   <= Y_CENTER;
    end else if (tick) begin
      state <= state_nxt;
      speed <= speed_nxt;
      y_q   <= y_nxt;
    end
  end

  assign pif.PaddleX = X_POS;
  assign pif.PaddleS = PADDLE_S;
  assign pif.PaddleY = y_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: latency, acceleration, clamping, release,
// game-over freeze, async reset and frame strobe edge handling.
module tb_paddle_ctrl;
  logic Clk = 1'b0;
  logic clk_en = 1'b1;
  logic Reset_n;
  logic frame_clk;
  int   n_pass = 0;
  int   n_chk  = 0;

  paddle_ctrl_if pif ();

  paddle_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .pif       (pif.slave)
  );

  always #5 if (clk_en) Clk = ~Clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One frame strobe raised just before a Clk rise; the update lands on the third edge.
  task automatic frame(input logic [7:0] key, input string tag, input logic [9:0] exp);
    pif.keycode = key;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 check(tag, pif.PaddleY, exp);
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic frames_nochk(input logic [7:0] key, input int n);
    pif.keycode = key;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (5) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  // Reset with the clock stopped: outputs must return immediately.
  task automatic async_reset(input string tag);
    @(negedge Clk);
    clk_en = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    check({tag, "_y"}, pif.PaddleY, 10'd240);
    check({tag, "_x"}, pif.PaddleX, 10'd40);
    check({tag, "_s"}, pif.PaddleS, 10'd24);
    #1 Reset_n = 1'b1;
    #1 clk_en = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    pif.keycode = 8'h00;
    pif.Score1  = 4'd0;
    pif.Score2  = 4'd0;
    repeat (3) @(negedge Clk);
    check("rst_y", pif.PaddleY, 10'd240);
    check("rst_x", pif.PaddleX, 10'd40);
    check("rst_s", pif.PaddleS, 10'd24);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // First up frame with explicit latency check at edge 2 and edge 3
    pif.keycode = 8'h1A;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 check("lat_edge2", pif.PaddleY, 10'd240);
    @(posedge Clk);
    #1 check("up1", pif.PaddleY, 10'd238);
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    frame(8'h1A, "up2", 10'd235);
    frame(8'h1A, "up3", 10'd231);
    frame(8'h1A, "up4", 10'd226);
    frame(8'h1A, "up5", 10'd220);
    frame(8'h1A, "up6", 10'd214);

    // Reverse, release, re-press
    frame(8'h16, "dn1", 10'd216);
    frame(8'h16, "dn2", 10'd219);
    frame(8'h16, "dn3", 10'd223);
    frame(8'h00, "rel1", 10'd223);
    frame(8'h00, "rel2", 10'd223);
    frame(8'h16, "repress", 10'd225);

    // Run into the bottom clamp, then set up Y=450
    frames_nochk(8'h16, 45);
    frame(8'h16, "bot_clamp", 10'd455);
    frame(8'h00, "bot_rel", 10'd455);
    frame(8'h1A, "bot_up1", 10'd453);
    frame(8'h1A, "bot_up2", 10'd450);
    frame(8'h00, "y450", 10'd450);
    frame(8'h16, "ramp1", 10'd452);
    frame(8'h16, "ramp2", 10'd455);
    frame(8'h16, "ramp3", 10'd455);
    frame(8'h16, "ramp4", 10'd455);
    frame(8'h1A, "switch_up", 10'd453);

    async_reset("areset1");

    // Game over freeze
    frames_nochk(8'h1A, 5);
    frame(8'h1A, "go_pre", 10'd214);
    pif.Score1 = 4'd10;
    frame(8'h1A, "go_center", 10'd240);
    frame(8'h1A, "frz_up", 10'd240);
    frame(8'h16, "frz_dn", 10'd240);
    pif.Score1 = 4'd0;
    frame(8'h1A, "frz_sticky", 10'd240);

    async_reset("areset2");
    frame(8'h1A, "unfrozen", 10'd238);

    async_reset("areset3");

    // Long-held strobe gives one step; a sub-cycle glitch between edges gives none
    pif.keycode = 8'h1A;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (80) @(negedge Clk);
    check("held_high", pif.PaddleY, 10'd238);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    check("held_fall", pif.PaddleY, 10'd238);
    @(negedge Clk);
    #1 frame_clk = 1'b1;
    #2 frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    check("glitch", pif.PaddleY, 10'd238);
    frame(8'h1A, "post_glitch", 10'd235);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
